// File: rtl/usb_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_frame
// Purpose  : RX deframer: sync hunt, header/length decode, payload-to-RAM
//            writes, XOR checksum check and status reporting to control.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_frame #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 12,
  parameter int                LEN_W   = 8,
  parameter logic [DATA_W-1:0] SYNC0   = 8'h55,
  parameter logic [DATA_W-1:0] SYNC1   = 8'hAA,
  parameter int                TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [DATA_W-1:0] rxd,
  input  logic              rxd_vld,
  input  logic [ADDR_W-1:0] ram_txa_init,
  output logic [ADDR_W-1:0] ram_txa,
  output logic [DATA_W-1:0] ram_txd,
  output logic              ram_txen,
  output logic [3:0]        btype,
  output logic [LEN_W-1:0]  rx_len,
  output logic [31:0]       cache_stat
);

  localparam int c_LEN_BYTES = (LEN_W + DATA_W - 1) / DATA_W;
  localparam int c_TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SYNC0 = 4'd1,
    ST_SYNC1 = 4'd2,
    ST_HDR   = 4'd3,
    ST_LEN   = 4'd4,
    ST_DATA  = 4'd5,
    ST_CHK   = 4'd6,
    ST_DONE  = 4'd7
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_chk;
  logic [2:0]          r_err;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [3:0]          r_len_idx;
  logic [c_TO_W-1:0]   r_tcnt;

  logic [LEN_W-1:0]    w_len_next;
  logic [LEN_W-1:0]    w_cnt_next;
  logic [15:0]         w_len16;

  // Length field arrives MSB first, one byte at a time.
  if (LEN_W > DATA_W) begin : g_len_wide
    assign w_len_next = {r_len[LEN_W-DATA_W-1:0], rxd};
  end else begin : g_len_narrow
    assign w_len_next = rxd[LEN_W-1:0];
  end

  assign w_cnt_next = r_cnt + LEN_W'(1);
  assign w_len16    = 16'(rx_len);
  assign cache_stat = {5'b0, r_err, 4'h0, btype, w_len16};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_chk     <= '0;
      r_err     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_len_idx <= '0;
      r_tcnt    <= '0;
      fd        <= 1'b0;
      ram_txa   <= '0;
      ram_txd   <= '0;
      ram_txen  <= 1'b0;
      btype     <= '0;
      rx_len    <= '0;
    end else begin
      ram_txen <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fs && !fd) begin
            r_addr    <= ram_txa_init;
            r_chk     <= '0;
            r_err     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_len_idx <= '0;
            r_tcnt    <= '0;
            btype     <= '0;
            rx_len    <= '0;
            r_state   <= ST_SYNC0;
          end
        end
        ST_DONE: begin
          if (!fs) begin
            fd      <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (!fs) begin
            r_state <= ST_IDLE;
          end else if (rxd_vld) begin
            r_tcnt <= '0;
            case (r_state)
              ST_SYNC0: begin
                if (rxd == SYNC0) r_state <= ST_SYNC1;
              end
              ST_SYNC1: begin
                if (rxd == SYNC1)      r_state <= ST_HDR;
                else if (rxd != SYNC0) r_state <= ST_SYNC0;
              end
              ST_HDR: begin
                // Checksum covers the length and payload bytes only.
                btype   <= rxd[7:4];
                r_state <= ST_LEN;
              end
              ST_LEN: begin
                r_chk     <= r_chk ^ rxd;
                r_len     <= w_len_next;
                r_len_idx <= r_len_idx + 4'd1;
                if (r_len_idx == 4'(c_LEN_BYTES - 1)) begin
                  if (w_len_next == '0) begin
                    r_err[1] <= 1'b1;
                    rx_len   <= '0;
                    fd       <= 1'b1;
                    r_state  <= ST_DONE;
                  end else begin
                    r_state  <= ST_DATA;
                  end
                end
              end
              ST_DATA: begin
                ram_txen <= 1'b1;
                ram_txd  <= rxd;
                ram_txa  <= r_addr;
                r_addr   <= r_addr + ADDR_W'(1);
                r_cnt    <= w_cnt_next;
                r_chk    <= r_chk ^ rxd;
                if (w_cnt_next == r_len) r_state <= ST_CHK;
              end
              ST_CHK: begin
                if (rxd != r_chk) r_err[0] <= 1'b1;
                rx_len  <= r_cnt;
                fd      <= 1'b1;
                r_state <= ST_DONE;
              end
              default: ;
            endcase
          end else if (r_state != ST_SYNC0) begin
            if (r_tcnt == c_TO_W'(TIMEOUT - 1)) begin
              r_err[2] <= 1'b1;
              rx_len   <= r_cnt;
              fd       <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_tcnt <= r_tcnt + c_TO_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_frame.sv
`default_nettype none
// Bench for usb_rx_frame: directed frames plus randomized frames checked
// against a stream-parsing reference model.
`timescale 1ns/1ps
module tb_usb_rx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs = 1'b0;
  logic        fd;
  logic [7:0]  rxd = 8'h00;
  logic        rxd_vld = 1'b0;
  logic [11:0] ram_txa_init = 12'h000;
  logic [11:0] ram_txa;
  logic [7:0]  ram_txd;
  logic        ram_txen;
  logic [3:0]  btype;
  logic [7:0]  rx_len;
  logic [31:0] cache_stat;

  usb_rx_frame dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .rxd(rxd), .rxd_vld(rxd_vld),
    .ram_txa_init(ram_txa_init), .ram_txa(ram_txa), .ram_txd(ram_txd),
    .ram_txen(ram_txen), .btype(btype), .rx_len(rx_len), .cache_stat(cache_stat)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stim[$];
  logic [11:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [3:0]  exp_btype;
  logic [7:0]  exp_len;
  logic [7:0]  exp_err;
  logic [11:0] last_wr_addr = 12'h000;
  logic        fd_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load n bytes (MSB first) from a packed vector into the stimulus stream.
  task automatic load(input logic [255:0] v, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Reference: find the first 55,AA pair, then header, length, payload, checksum.
  // A stream that ends before the checksum is treated as a timeout.
  task automatic model_frame(input logic [11:0] base);
    int j, p, n, len, written;
    logic [7:0] x, h;
    j = -1; n = stim.size();
    exp_btype = 4'h0; exp_err = 8'h00; exp_len = 8'h00;
    for (int i = 0; i + 1 < n; i++)
      if (j < 0 && stim[i] == 8'h55 && stim[i+1] == 8'hAA) j = i;
    p = j + 2;
    if (j < 0 || p >= n) begin exp_err = 8'h04; return; end
    h = stim[p]; exp_btype = h[7:4]; p++;
    if (p >= n) begin exp_err = 8'h04; return; end
    len = int'(stim[p]); x = stim[p]; p++;
    if (len == 0) begin exp_err = 8'h02; return; end
    written = 0;
    for (int k = 0; k < len && p < n; k++) begin
      exp_addr_q.push_back(base + 12'(k));
      exp_data_q.push_back(stim[p]);
      x ^= stim[p]; p++; written++;
    end
    exp_len = 8'(written);
    if (written < len || p >= n) begin exp_err = 8'h04; return; end
    exp_err = (stim[p] == x) ? 8'h00 : 8'h01;
  endtask

  // Compare process: every RAM write and the status at fd rise.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_txen) begin
        if (exp_addr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_txa, ram_txd);
        end else begin
          check("wr_addr", 32'(ram_txa), 32'(exp_addr_q.pop_front()));
          check("wr_data", 32'(ram_txd), 32'(exp_data_q.pop_front()));
        end
        last_wr_addr <= ram_txa;
      end
      if (fd && !fd_q) begin
        check("btype", 32'(btype), 32'(exp_btype));
        check("rx_len", 32'(rx_len), 32'(exp_len));
        check("cache_stat", cache_stat, {exp_err, 4'h0, exp_btype, 8'h00, exp_len});
      end
      fd_q <= fd;
    end else begin
      fd_q <= 1'b0;
    end
  end

  task automatic start_frame(input logic [11:0] base);
    exp_addr_q.delete(); exp_data_q.delete();
    model_frame(base);
    ram_txa_init = base; fs = 1'b1;
    @(posedge clk); #1;
    ram_txa_init = 12'($urandom);
  endtask

  task automatic drive_bytes(input int gap_max);
    foreach (stim[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      rxd = stim[i]; rxd_vld = 1'b1;
      @(posedge clk); #1;
      rxd_vld = 1'b0; rxd = 8'($urandom);
    end
  endtask

  task automatic run_frame(input logic [11:0] base, input int gap_max, input bit tmo,
                           input bit lit_en, input logic [31:0] lit_stat);
    int waited;
    start_frame(base);
    drive_bytes(gap_max);
    waited = 0;
    while (!fd && waited < 2000) begin @(negedge clk); waited++; end
    check("fd_seen", 32'(fd), 32'd1);
    if (lit_en) check("literal_stat", cache_stat, lit_stat);
    if (tmo) check("timeout_latency", 32'(waited >= 1023 && waited <= 1027), 32'd1);
    @(posedge clk); #1; fs = 1'b0;
    @(posedge clk); #1;
    check("fd_drop", 32'(fd), 32'd0);
    check("writes_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("reset_fd", 32'(fd), 32'd0);
    check("reset_txen", 32'(ram_txen), 32'd0);
    check("reset_stat", cache_stat, 32'd0);
    check("reset_txa", 32'(ram_txa), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    load(256'h55AA300311223303, 8);
    run_frame(12'h100, 0, 1'b0, 1'b1, 32'h0003_0003);

    load(256'h0055_55AA300311223303, 10);
    run_frame(12'h100, 2, 1'b0, 1'b1, 32'h0003_0003);

    load(256'h55AA3003112233FF, 8);
    run_frame(12'h100, 1, 1'b0, 1'b1, 32'h0103_0003);

    load(256'h55AA3000, 4);
    run_frame(12'h080, 0, 1'b0, 1'b1, 32'h0203_0000);

    load(256'h55AA5002A1B2, 6);
    run_frame(12'h300, 0, 1'b1, 1'b1, 32'h0405_0002);

    load(256'h55AA70040102030400, 9);
    run_frame(12'hFFE, 0, 1'b0, 1'b1, 32'h0007_0004);
    check("wrap_last_addr", 32'(last_wr_addr), 32'h001);

    // fs abort mid-payload: the write already in flight still lands.
    load(256'h55AA300501, 5);
    start_frame(12'h400);
    drive_bytes(0);
    fs = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("abort_no_fd", 32'(fd), 32'd0);
    check("abort_write_done", 32'(exp_addr_q.size()), 32'd0);

    // Asynchronous reset in the middle of the payload.
    load(256'h55AA30040102, 6);
    start_frame(12'h200);
    drive_bytes(0);
    check("pre_reset_txen", 32'(ram_txen), 32'd1);
    rst = 1'b0; #1;
    check("rst_txen", 32'(ram_txen), 32'd0);
    check("rst_fd", 32'(fd), 32'd0);
    fs = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    load(256'h55AA300311223303, 8);
    run_frame(12'h100, 0, 1'b0, 1'b1, 32'h0003_0003);

    for (int t = 0; t < 25; t++) begin
      int len, ng;
      logic [7:0] x, b;
      stim.delete();
      ng = $urandom_range(4, 0);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h00;
        stim.push_back(b);
      end
      if ($urandom_range(1, 0) == 1) stim.push_back(8'h55);
      stim.push_back(8'h55); stim.push_back(8'hAA);
      stim.push_back(8'($urandom));
      len = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(24, 1);
      stim.push_back(8'(len)); x = 8'(len);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom); stim.push_back(b); x ^= b;
      end
      if (len != 0) stim.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'h5A) : x);
      run_frame(12'($urandom), 3, 1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
